// File: rtl/nes_mem_arbiter.sv
// Shares the byte-wide SDRAM port between the game loader (buffered, slot-timed writes)
// and the NES core (run-time pass-through). Optional ROM write protection: NES_ROM_WP_EN.
module nes_mem_arbiter #(
  parameter logic [1:0]  SLOT_PHASE = 2'd3,
  parameter int          MEM_AW     = 25,
  parameter logic [21:0] ROM_LIMIT  = 22'h100000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        nes_ce,
  input  logic              load_done,
  input  logic              ldr_valid,
  input  logic [21:0]       ldr_addr,
  input  logic [7:0]        ldr_data,
  output logic              ldr_ready,
  input  logic [21:0]       nes_addr,
  input  logic              nes_write,
  input  logic [7:0]        nes_dout,
  input  logic              nes_read_cpu,
  input  logic              nes_read_ppu,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_din,
  output logic              mem_oeA,
  output logic              mem_oeB,
  output logic              sd_tristate,
  output logic              loading,
  output logic              wp_violation
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_DRAIN = 2'd1,
    S_RUN   = 2'd2
  } state_t;

`ifdef NES_ROM_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  state_t              r_state;
  state_t              w_nextState;
  logic                r_bufFull;
  logic [21:0]         r_bufAddr;
  logic [7:0]          r_bufData;
  logic                r_memWe;
  logic [MEM_AW-1:0]   r_memAddr;
  logic [7:0]          r_memDin;
  logic                w_accept;
  logic                w_slot;
  logic                w_blocked;

  assign w_slot    = (nes_ce == SLOT_PHASE);
  assign ldr_ready = (r_state == S_LOAD) && !r_bufFull;
  assign w_accept  = ldr_valid && ldr_ready;
  assign loading   = (r_state != S_RUN);
  assign w_blocked = WP_EN && nes_write && (nes_addr < ROM_LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_LOAD;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_LOAD:  if (load_done) w_nextState = S_DRAIN;
      // RUN only once the last loader write window has fully closed
      S_DRAIN: if (!r_bufFull && !r_memWe) w_nextState = S_RUN;
      S_RUN:   if (!load_done) w_nextState = S_LOAD;
      default: w_nextState = S_LOAD;
    endcase
  end

  // Accept never coincides with issue: ready requires an empty buffer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bufFull <= 1'b0;
      r_bufAddr <= '0;
      r_bufData <= '0;
      r_memWe   <= 1'b0;
      r_memAddr <= '0;
      r_memDin  <= '0;
    end else begin
      if (w_accept) begin
        r_bufFull <= 1'b1;
        r_bufAddr <= ldr_addr;
        r_bufData <= ldr_data;
      end
      if (r_state == S_RUN) begin
        r_memWe <= 1'b0;
      end else if (w_slot) begin
        if (r_bufFull) begin
          r_memWe   <= 1'b1;
          r_memAddr <= MEM_AW'(r_bufAddr);
          r_memDin  <= r_bufData;
          r_bufFull <= 1'b0;
        end else begin
          r_memWe <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    mem_addr = r_memAddr;
    mem_din  = r_memDin;
    mem_we   = r_memWe;
    mem_oeA  = 1'b0;
    mem_oeB  = 1'b0;
    if (r_state == S_RUN) begin
      mem_addr = MEM_AW'(nes_addr);
      mem_din  = nes_dout;
      mem_we   = nes_write && !w_blocked;
      mem_oeA  = nes_read_cpu;
      mem_oeB  = nes_read_ppu;
    end
  end

  assign sd_tristate = !mem_we;

`ifdef NES_ROM_WP_EN
  logic r_wpViolation;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wpViolation <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (!load_done)     r_wpViolation <= 1'b0;
      else if (w_blocked) r_wpViolation <= 1'b1;
    end
  end

  assign wp_violation = r_wpViolation;
`else
  assign wp_violation = 1'b0;
`endif

endmodule
